conv_window_feeder: RTL and testbench
=====================================

CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

Interface
REQ-001 Parameter IMG_W, default 8: image width in pixels, min 3.
REQ-002 Parameter IMG_H, default 8: image height in pixels, min 3.
REQ-003 Parameter DATA_W, default 32: pixel and result width in bits.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1: reset, asynchronous and active-low.
REQ-006 pix_in  in  DATA_W: raster-order pixel stream, row-major, top-left first.
REQ-007 pix_valid / pix_ready  in / out  1: pixel handshake; a transfer occurs when both are high on a clock edge.
REQ-008 img_bit_0 .. img_bit_8  out  DATA_W each: 3x3 window to the dot-product module, row-major; img_bit_0 is top-left, img_bit_8 is the newest pixel.
REQ-009 initate  out  1: start pulse to the dot-product module.
REQ-010 Result_out  in  DATA_W: signed dot-product result.
REQ-011 ready_dot  in  1: dot-product completion strobe.
REQ-012 res_out / res_valid / res_ready  out / out / in  DATA_W / 1 / 1: result stream; a transfer occurs when res_valid and res_ready are both high.
REQ-013 frame_done  out  1: one-cycle pulse on the final result transfer of a frame.

Function
REQ-014 The FSM SHALL have states FILL, ISSUE, WAIT and OUTPUT.
REQ-015 Storage SHALL be two line buffers of IMG_W words plus a 3x3 shift window, with column and row counters that wrap at IMG_W-1 and IMG_H-1.
REQ-016 pix_ready SHALL be high only in FILL.
REQ-017 On an accepted pixel at (row, col) with row>=2 and col>=2, the FSM SHALL go to ISSUE; otherwise it SHALL stay in FILL.
REQ-018 initate SHALL be high for exactly one cycle, in ISSUE, which is the cycle after the pixel is accepted; the FSM then goes to WAIT.
REQ-019 img_bit_0..8 SHALL remain stable from ISSUE until the cycle after ready_dot is sampled high.
REQ-020 In WAIT, when ready_dot is sampled high, Result_out SHALL be captured and the FSM SHALL go to OUTPUT; res_valid rises on the next cycle.
REQ-021 res_out and res_valid SHALL hold until res_ready is high; on that transfer the FSM SHALL return to FILL.
REQ-022 Each frame SHALL produce exactly (IMG_W-2)*(IMG_H-2) results, in raster order of window position.
REQ-023 frame_done SHALL pulse on the last result transfer; the counters then SHALL restart at (0,0) for the next frame.
REQ-024 A ready_dot seen outside WAIT SHALL be ignored.
REQ-025 Pixels accepted at col 0 or col 1 of row>=2 SHALL only shift the window and SHALL NOT issue.

Reset
REQ-026 While rst_n is low, all of the following SHALL be 0: state=FILL, counters, window registers, line buffers, img_bit_*, initate, res_out, res_valid, frame_done.
REQ-027 pix_ready SHALL be 1 after reset is released.
REQ-028 A reset asserted mid-frame, including in WAIT or OUTPUT, SHALL discard the partial frame; the next pixel accepted is (0,0).

Configuration
REQ-029 Macro FEEDER_RELU_EN: when defined, a captured Result_out with its MSB set SHALL be replaced by 0 in res_out; when undefined, res_out SHALL equal the captured Result_out bit-exact.

Verification
REQ-030 IMG_W=IMG_H=4, pixels 1..16, responder returning the sum of the 9 window values with ready_dot 3 cycles after initate -> res_out 54, 63, 90, 99 in order; frame_done with 99; pix_ready low from ISSUE through OUTPUT.
REQ-031 Same frame, res_ready held low 10 cycles on the first result -> res_out stays 54 and res_valid stays high; no further initate until the transfer.
REQ-032 Spurious ready_dot in FILL -> no res_valid and no state change.
REQ-033 rst_n pulsed low in WAIT of the second window -> all outputs 0; a fresh 16-pixel frame then yields 54, 63, 90, 99.
REQ-034 FEEDER_RELU_EN defined and responder returning 0xFFFFFFF6 -> res_out 0; macro undefined -> res_out 0xFFFFFFF6.
REQ-035 Two back-to-back 4x4 frames -> 8 results and two frame_done pulses, with the second frame's first window equal to that of the first frame.

Source files
------------

// File: rtl/conv_window_feeder.sv
// Streams raster pixels through two line buffers into a 3x3 window, hands each
// full window to an external dot-product unit and forwards its result. Optional macro: FEEDER_RELU_EN.
module conv_window_feeder #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [DATA_W-1:0] img_bit_0,
  output logic [DATA_W-1:0] img_bit_1,
  output logic [DATA_W-1:0] img_bit_2,
  output logic [DATA_W-1:0] img_bit_3,
  output logic [DATA_W-1:0] img_bit_4,
  output logic [DATA_W-1:0] img_bit_5,
  output logic [DATA_W-1:0] img_bit_6,
  output logic [DATA_W-1:0] img_bit_7,
  output logic [DATA_W-1:0] img_bit_8,
  output logic              initate,
  input  logic [DATA_W-1:0] Result_out,
  input  logic              ready_dot,
  output logic [DATA_W-1:0] res_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {FILL, ISSUE, WAIT, OUTPUT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] line0 [IMG_W];  // previous row
  logic [DATA_W-1:0] line1 [IMG_W];  // row before that
  logic [DATA_W-1:0] win   [9];
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              last_win;
  logic              accept;
  logic [DATA_W-1:0] res_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block is defaulted first; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    pix_ready  = 1'b0;
    initate    = 1'b0;
    res_valid  = 1'b0;
    frame_done = 1'b0;
    accept     = 1'b0;
    case (state)
      FILL: begin
        pix_ready = 1'b1;
        accept    = pix_valid;
        if (pix_valid && row >= ROW_TWO && col >= COL_TWO) state_nxt = ISSUE;
      end
      ISSUE: begin
        initate   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (ready_dot) state_nxt = OUTPUT;
      OUTPUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt  = FILL;
          frame_done = last_win;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // NOTE: the line buffers carry an async clear because the whole datapath must
  // read zero in reset; this keeps them as flops rather than block RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        line0[i] <= '0;
        line1[i] <= '0;
      end
      for (int k = 0; k < 9; k++) win[k] <= '0;
      col      <= '0;
      row      <= '0;
      last_win <= 1'b0;
      res_q    <= '0;
    end else begin
      if (accept) begin
        // Window shifts left one column; the new right column is rows r-2, r-1, r.
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= line1[col];
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= line0[col];
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= pix_in;
        line1[col] <= line0[col];
        line0[col] <= pix_in;
        last_win   <= (row == ROW_LAST) && (col == COL_LAST);
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (state == WAIT && ready_dot) begin
`ifdef FEEDER_RELU_EN
        res_q <= Result_out[DATA_W-1] ? '0 : Result_out;
`else
        res_q <= Result_out;
`endif
      end
    end
  end

  assign img_bit_0 = win[0];
  assign img_bit_1 = win[1];
  assign img_bit_2 = win[2];
  assign img_bit_3 = win[3];
  assign img_bit_4 = win[4];
  assign img_bit_5 = win[5];
  assign img_bit_6 = win[6];
  assign img_bit_7 = win[7];
  assign img_bit_8 = win[8];
  assign res_out   = res_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Scoreboard bench for conv_window_feeder: a frame model pushes expected window
// sums, a monitor pops them on every result transfer. Honours FEEDER_RELU_EN.
module tb_conv_window_feeder;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 32;
  localparam logic [31:0] FIX = 32'hFFFF_FFF6;
`ifdef FEEDER_RELU_EN
  localparam logic [31:0] FIX_EXP = 32'h0;
`else
  localparam logic [31:0] FIX_EXP = FIX;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [DW-1:0] img_bit [9];
  logic          initate;
  logic [DW-1:0] Result_out = '0;
  logic          ready_dot = 1'b0;
  logic [DW-1:0] res_out;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic          frame_done;

  conv_window_feeder #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .img_bit_0(img_bit[0]), .img_bit_1(img_bit[1]), .img_bit_2(img_bit[2]),
    .img_bit_3(img_bit[3]), .img_bit_4(img_bit[4]), .img_bit_5(img_bit[5]),
    .img_bit_6(img_bit[6]), .img_bit_7(img_bit[7]), .img_bit_8(img_bit[8]),
    .initate(initate), .Result_out(Result_out), .ready_dot(ready_dot),
    .res_out(res_out), .res_valid(res_valid), .res_ready(res_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] val;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] frame [H][W];
  int n_checks = 0, n_fail = 0;
  int fd_count = 0, init_count = 0;
  int spur_req = 0, spur_done = 0;
  bit hold_rr = 0, rr_random = 0, gaps = 0, fixed_mode = 0, abort = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Result backpressure
  always @(negedge clk)
    res_ready = hold_rr ? 1'b0 : (rr_random ? 1'($urandom_range(0, 1)) : 1'b1);

  // Dot-product stand-in: sums the window, answers 3 cycles after initate.
  int          resp_cnt = 0;
  logic [31:0] resp_val = '0;
  always @(negedge clk) begin
    ready_dot = 1'b0;
    if (!rst_n) begin
      resp_cnt = 0;
    end else if (resp_cnt != 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        ready_dot  = 1'b1;
        Result_out = resp_val;
      end
    end else if (initate) begin
      resp_cnt = 3;
      resp_val = '0;
      for (int i = 0; i < 9; i++) resp_val += img_bit[i];
      if (fixed_mode) resp_val = FIX;
    end else if (spur_req != spur_done) begin
      ready_dot  = 1'b1;
      Result_out = 32'd777;
      spur_done  = spur_req;
    end
  end

  // Monitor: samples just after the falling edge, pops on every transfer.
  logic prev_init = 1'b0;
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (initate) begin
        init_count++;
        check("initate_one_cycle", 32'(prev_init), 0);
        check("pix_ready_in_issue", 32'(pix_ready), 0);
      end
      if (res_valid) check("pix_ready_in_output", 32'(pix_ready), 0);
      if (frame_done) begin
        fd_count++;
        check("frame_done_on_transfer", 32'(res_valid && res_ready), 1);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("result_without_expectation", 32'(exp_q.size()), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("res_out", res_out, e.val);
          check("frame_done", 32'(frame_done), 32'(e.last));
        end
      end
      prev_init = initate;
    end else begin
      prev_init = 1'b0;
    end
  end

  // Reference model: each window sum straight from the 2-D frame, raster order.
  task automatic gen_frame(input bit directed);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frame[r][c] = directed ? 32'(r * W + c + 1) : 32'($urandom_range(0, 100000));
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        exp_t e;
        logic [31:0] s = '0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++) s += frame[r-dr][c-dc];
        e.val  = fixed_mode ? FIX_EXP : s;
        e.last = (r == H - 1) && (c == W - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic push_pixel(input logic [31:0] v);
    if (gaps && $urandom_range(0, 2) == 0) begin
      pix_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    pix_in    = v;
    pix_valid = 1'b1;
    for (int t = 0; t < 300 && !pix_ready && !abort; t++) @(negedge clk);
    if (abort) begin
      pix_valid = 1'b0;
      return;
    end
    check("pix_ready_wait", 32'(pix_ready), 1);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic feed_frame(input bit directed);
    gen_frame(directed);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (abort) return;
        push_pixel(frame[r][c]);
      end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 1000 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 9; i++) check({tag, "_img_bit"}, img_bit[i], 0);
    check({tag, "_initate"}, 32'(initate), 0);
    check({tag, "_res_out"}, res_out, 0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
  endtask

  task automatic stall_check();
    for (int t = 0; t < 400 && !res_valid; t++) @(negedge clk);
    #1;
    check("stall_valid_seen", 32'(res_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("stall_res_valid", 32'(res_valid), 1);
      check("stall_res_out", res_out, 32'd54);
      check("stall_no_initate", 32'(initate), 0);
    end
    hold_rr = 1'b0;
  endtask

  task automatic reset_in_wait();
    int base = init_count;
    for (int t = 0; t < 500 && init_count < base + 2; t++) @(negedge clk);
    check("second_window_issued", 32'(init_count - base), 2);
    abort = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    abort = 1'b0;
  endtask

  initial begin
    int fd0, in0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("pix_ready_after_reset", 32'(pix_ready), 1);

    // Directed 1..16 frame: 54, 63, 90, 99
    fd0 = fd_count; in0 = init_count;
    feed_frame(1'b1);
    wait_drain();
    check("frame1_done_count", 32'(fd_count - fd0), 1);
    check("frame1_initate_count", 32'(init_count - in0), 4);

    // First result held off for 10 cycles
    hold_rr = 1'b1;
    fork
      feed_frame(1'b1);
      stall_check();
    join
    wait_drain();

    // Spurious completion strobe while idle
    spur_req++;
    repeat (6) begin
      @(negedge clk);
      #1;
      check("spurious_res_valid", 32'(res_valid), 0);
      check("spurious_pix_ready", 32'(pix_ready), 1);
    end
    @(negedge clk);
    feed_frame(1'b1);
    wait_drain();

    // Reset during WAIT of the second window, then a clean frame
    fork
      feed_frame(1'b1);
      reset_in_wait();
    join
    @(negedge clk);
    check("pix_ready_after_mid_reset", 32'(pix_ready), 1);
    fd0 = fd_count;
    feed_frame(1'b1);
    wait_drain();
    check("post_reset_done_count", 32'(fd_count - fd0), 1);

    // Negative result passthrough / clamp
    fixed_mode = 1'b1;
    feed_frame(1'b0);
    wait_drain();
    fixed_mode = 1'b0;

    // Back-to-back frames
    fd0 = fd_count; in0 = init_count;
    feed_frame(1'b1);
    feed_frame(1'b1);
    wait_drain();
    check("b2b_done_count", 32'(fd_count - fd0), 2);
    check("b2b_initate_count", 32'(init_count - in0), 8);

    // Random frames with pixel gaps and random backpressure
    rr_random = 1'b1;
    gaps = 1'b1;
    fd0 = fd_count;
    for (int f = 0; f < 4; f++) feed_frame(1'b0);
    wait_drain();
    check("random_done_count", 32'(fd_count - fd0), 4);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
